// File: rtl/rob_commit_unit_pkg.sv
// Shared types for the reorder buffer: entry layout, store opcode, popcount helper.
package rob_commit_unit_pkg;
    localparam int DATA_W = 32;
    localparam int PREG_W = 6;
    localparam int AREG_W = 5;

    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef struct packed {
        logic              v;
        logic              comp;
        logic              store;
        logic [AREG_W-1:0] areg;
        logic [PREG_W-1:0] preg;
        logic [PREG_W-1:0] old_preg;
        logic [DATA_W-1:0] result;
    } rob_entry_t;

    function automatic int unsigned popcnt(input logic [31:0] m);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) n += 32'(m[i]);
        return n;
    endfunction
endpackage

// File: rtl/rob_commit_unit_if.sv
// Dispatch / completion / forward / retire bus between the pipeline and the ROB.
interface rob_commit_unit_if #(
    parameter int DEPTH      = 16,
    parameter int DISPATCH_W = 2,
    parameter int COMPLETE_W = 3,
    parameter int RETIRE_W   = 2
);
    import rob_commit_unit_pkg::*;
    localparam int TAG_W = $clog2(DEPTH);

    logic [DISPATCH_W-1:0]             alloc_valid_i;
    logic [DISPATCH_W-1:0][6:0]        alloc_op_i;
    logic [DISPATCH_W-1:0][AREG_W-1:0] alloc_areg_i;
    logic [DISPATCH_W-1:0][PREG_W-1:0] alloc_preg_i;
    logic [DISPATCH_W-1:0][PREG_W-1:0] alloc_old_preg_i;
    logic                              alloc_ready_o;
    logic [DISPATCH_W-1:0][TAG_W-1:0]  alloc_tag_o;

    logic [COMPLETE_W-1:0]             cmp_valid_i;
    logic [COMPLETE_W-1:0][TAG_W-1:0]  cmp_tag_i;
    logic [COMPLETE_W-1:0][DATA_W-1:0] cmp_data_i;
    logic [COMPLETE_W-1:0]             fwd_valid_o;
    logic [COMPLETE_W-1:0][PREG_W-1:0] fwd_preg_o;
    logic [COMPLETE_W-1:0][DATA_W-1:0] fwd_data_o;

    logic [RETIRE_W-1:0]               rt_valid_o;
    logic [RETIRE_W-1:0]               rt_wr_o;
    logic [RETIRE_W-1:0]               rt_store_o;
    logic [RETIRE_W-1:0][AREG_W-1:0]   rt_areg_o;
    logic [RETIRE_W-1:0][PREG_W-1:0]   rt_preg_o;
    logic [RETIRE_W-1:0][DATA_W-1:0]   rt_data_o;
    logic [RETIRE_W-1:0][PREG_W-1:0]   rt_free_preg_o;

    modport master (
        output alloc_valid_i, alloc_op_i, alloc_areg_i, alloc_preg_i, alloc_old_preg_i,
        output cmp_valid_i, cmp_tag_i, cmp_data_i,
        input  alloc_ready_o, alloc_tag_o, fwd_valid_o, fwd_preg_o, fwd_data_o,
        input  rt_valid_o, rt_wr_o, rt_store_o, rt_areg_o, rt_preg_o, rt_data_o, rt_free_preg_o
    );

    modport slave (
        input  alloc_valid_i, alloc_op_i, alloc_areg_i, alloc_preg_i, alloc_old_preg_i,
        input  cmp_valid_i, cmp_tag_i, cmp_data_i,
        output alloc_ready_o, alloc_tag_o, fwd_valid_o, fwd_preg_o, fwd_data_o,
        output rt_valid_o, rt_wr_o, rt_store_o, rt_areg_o, rt_preg_o, rt_data_o, rt_free_preg_o
    );
endinterface

// File: rtl/rob_commit_unit_retire_select.sv
// Prefix scan over the head window: lane k retires only if lanes 0..k are all ready.
module rob_retire_select #(
    parameter int RETIRE_W = 2
) (
    input  logic [RETIRE_W-1:0] rdy_i,
    output logic [RETIRE_W-1:0] mask_o
);
    // Running AND stops retirement at the first incomplete entry
    always_comb begin
        logic run;
        mask_o = '0;
        run    = 1'b1;
        for (int k = 0; k < RETIRE_W; k++) begin
            run       = run & rdy_i[k];
            mask_o[k] = run;
        end
    end
endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer: in-order allocate, tag-addressed completion with forwarding,
// in-order retire with old-preg release, retired-instruction counter and done flag.
module rob_commit_unit
    import rob_commit_unit_pkg::*;
#(
    parameter int  DEPTH      = 16,
    parameter int  DISPATCH_W = 2,
    parameter int  COMPLETE_W = 3,
    parameter int  RETIRE_W   = 2,
    localparam int TAG_W      = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    rob_commit_unit_if.slave  bus,
    input  logic [31:0]       tot_instr_i,
    output logic [31:0]       retired_cnt_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              full_o
);
    rob_entry_t          rob_q [DEPTH];
    rob_entry_t          win_e [RETIRE_W];
    logic [TAG_W-1:0]    head_q, tail_q;
    logic [CNT_W-1:0]    count_q, n_alloc, n_ret;
    logic [RETIRE_W-1:0] win_rdy, rt_mask;
    logic [31:0]         retired_q, cnt_next;
    logic [32:0]         cnt_sum;
    logic                done_q;

    // Space check uses start-of-cycle occupancy only
    assign bus.alloc_ready_o = (CNT_W'(DEPTH) - count_q) >= CNT_W'(DISPATCH_W);
    assign n_alloc = bus.alloc_ready_o ? CNT_W'(popcnt(32'(bus.alloc_valid_i))) : '0;
    assign n_ret   = CNT_W'(popcnt(32'(rt_mask)));

    assign cnt_sum  = {1'b0, retired_q} + 33'(n_ret);
    assign cnt_next = cnt_sum[32] ? '1 : cnt_sum[31:0];

    assign count_o       = count_q;
    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == CNT_W'(DEPTH));
    assign retired_cnt_o = retired_q;
    assign done_o        = done_q;

    // Lane tags are consecutive slots from the tail
    always_comb begin
        for (int k = 0; k < DISPATCH_W; k++) bus.alloc_tag_o[k] = tail_q + TAG_W'(k);
    end

    // Gather the head window for the retire scan
    always_comb begin
        for (int k = 0; k < RETIRE_W; k++) begin
            win_e[k]   = rob_q[head_q + TAG_W'(k)];
            win_rdy[k] = win_e[k].v & win_e[k].comp;
        end
    end

    rob_retire_select #(.RETIRE_W(RETIRE_W)) u_sel (
        .rdy_i  (win_rdy),
        .mask_o (rt_mask)
    );

    // Entry array and pointers; completions first so a later port overrides an earlier one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) rob_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i].v    <= 1'b0;
                rob_q[i].comp <= 1'b0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int p = 0; p < COMPLETE_W; p++) begin
                if (bus.cmp_valid_i[p] && rob_q[bus.cmp_tag_i[p]].v) begin
                    rob_q[bus.cmp_tag_i[p]].comp   <= 1'b1;
                    rob_q[bus.cmp_tag_i[p]].result <= bus.cmp_data_i[p];
                end
            end
            for (int k = 0; k < RETIRE_W; k++) begin
                if (rt_mask[k]) rob_q[head_q + TAG_W'(k)] <= '0;
            end
            if (bus.alloc_ready_o) begin
                for (int k = 0; k < DISPATCH_W; k++) begin
                    if (bus.alloc_valid_i[k]) begin
                        rob_q[tail_q + TAG_W'(k)] <= '{v: 1'b1, comp: 1'b0,
                            store: (bus.alloc_op_i[k] == OP_STORE),
                            areg: bus.alloc_areg_i[k], preg: bus.alloc_preg_i[k],
                            old_preg: bus.alloc_old_preg_i[k], result: '0};
                    end
                end
            end
            head_q  <= head_q + TAG_W'(n_ret);
            tail_q  <= tail_q + TAG_W'(n_alloc);
            count_q <= count_q + n_alloc - n_ret;
        end
    end

    // Registered forward, retire and progress outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fwd_valid_o    <= '0;
            bus.fwd_preg_o     <= '0;
            bus.fwd_data_o     <= '0;
            bus.rt_valid_o     <= '0;
            bus.rt_wr_o        <= '0;
            bus.rt_store_o     <= '0;
            bus.rt_areg_o      <= '0;
            bus.rt_preg_o      <= '0;
            bus.rt_data_o      <= '0;
            bus.rt_free_preg_o <= '0;
            retired_q          <= '0;
            done_q             <= 1'b0;
        end else if (flush_i) begin
            bus.fwd_valid_o    <= '0;
            bus.fwd_preg_o     <= '0;
            bus.fwd_data_o     <= '0;
            bus.rt_valid_o     <= '0;
            bus.rt_wr_o        <= '0;
            bus.rt_store_o     <= '0;
            bus.rt_areg_o      <= '0;
            bus.rt_preg_o      <= '0;
            bus.rt_data_o      <= '0;
            bus.rt_free_preg_o <= '0;
        end else begin
            for (int p = 0; p < COMPLETE_W; p++) begin
                bus.fwd_valid_o[p] <= bus.cmp_valid_i[p] && rob_q[bus.cmp_tag_i[p]].v;
                bus.fwd_preg_o[p]  <= rob_q[bus.cmp_tag_i[p]].preg;
                bus.fwd_data_o[p]  <= bus.cmp_data_i[p];
            end
            for (int k = 0; k < RETIRE_W; k++) begin
                bus.rt_valid_o[k]     <= rt_mask[k];
                bus.rt_wr_o[k]        <= rt_mask[k] & ~win_e[k].store;
                bus.rt_store_o[k]     <= rt_mask[k] & win_e[k].store;
                bus.rt_areg_o[k]      <= rt_mask[k] ? win_e[k].areg     : '0;
                bus.rt_preg_o[k]      <= rt_mask[k] ? win_e[k].preg     : '0;
                bus.rt_data_o[k]      <= rt_mask[k] ? win_e[k].result   : '0;
                bus.rt_free_preg_o[k] <= rt_mask[k] ? win_e[k].old_preg : '0;
            end
            retired_q <= cnt_next;
            done_q    <= done_q | ((tot_instr_i != '0) && (cnt_next >= tot_instr_i));
        end
    end
endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: per-cycle vector table plus hand sequences
// for full/wrap, flush and done.
module tb_rob_commit_unit;
    import rob_commit_unit_pkg::*;

    localparam int DEPTH = 16, DW = 2, CW = 3, RW = 2, CNT_W = 5;

    logic              clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic [31:0]       tot = '0, retired_cnt;
    logic              done, empty, full;
    logic [CNT_W-1:0]  count;

    rob_commit_unit_if #(.DEPTH(DEPTH), .DISPATCH_W(DW), .COMPLETE_W(CW), .RETIRE_W(RW)) bus ();

    rob_commit_unit #(.DEPTH(DEPTH), .DISPATCH_W(DW), .COMPLETE_W(CW), .RETIRE_W(RW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush),
        .bus           (bus),
        .tot_instr_i   (tot),
        .retired_cnt_o (retired_cnt),
        .done_o        (done),
        .count_o       (count),
        .empty_o       (empty),
        .full_o        (full)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    typedef struct {
        logic [1:0]       av;   logic st;  logic [4:0] a;
        logic [2:0]       cv;   logic [2:0][3:0] ct;  logic [2:0][31:0] cd;
        logic [4:0]       e_cnt; logic e_rdy;
        logic [1:0]       e_rv, e_wr, e_st;
        logic [31:0]      e_d0, e_d1; logic [5:0] e_f0, e_f1;
        logic [2:0]       e_fv; logic [31:0] e_fd0; logic [5:0] e_fp0;
    } vec_t;
    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        bus.alloc_valid_i = '0; bus.alloc_op_i = '0; bus.alloc_areg_i = '0;
        bus.alloc_preg_i = '0; bus.alloc_old_preg_i = '0;
        bus.cmp_valid_i = '0; bus.cmp_tag_i = '0; bus.cmp_data_i = '0;
        flush = 1'b0;
    endtask

    // lane k: areg = old = a+k, preg = a+k+30
    task automatic set_alloc(input logic [1:0] v, input logic [4:0] a, input logic st);
        bus.alloc_valid_i = v;
        for (int k = 0; k < DW; k++) begin
            bus.alloc_op_i[k]       = st ? OP_STORE : 7'h33;
            bus.alloc_areg_i[k]     = a + 5'(k);
            bus.alloc_preg_i[k]     = 6'(a) + 6'(k) + 6'd30;
            bus.alloc_old_preg_i[k] = 6'(a) + 6'(k);
        end
    endtask

    task automatic set_cmp(input int p, input logic [3:0] t, input logic [31:0] d);
        bus.cmp_valid_i[p] = 1'b1;
        bus.cmp_tag_i[p]   = t;
        bus.cmp_data_i[p]  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        clear_in();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: reset state
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_ready", bus.alloc_ready_o, 1);
        chk("rst_full", full, 0);
        chk("rst_rt_valid", bus.rt_valid_o, 0);
        chk("rst_fwd_valid", bus.fwd_valid_o, 0);
        chk("rst_done", done, 0);
        chk("rst_retired", retired_cnt, 0);

        // Table: out-of-order completion, store retire, duplicate/invalid tags
        vt[0] = '{default: '0, av: 2'b11, a: 5'd3, e_cnt: 2, e_rdy: 1};
        vt[1] = '{default: '0, cv: 3'b001, ct: {4'd0, 4'd0, 4'd1}, cd: {32'h0, 32'h0, 32'hBEEF},
                  e_cnt: 2, e_rdy: 1, e_fv: 3'b001, e_fd0: 32'hBEEF, e_fp0: 6'd34};
        vt[2] = '{default: '0, cv: 3'b001, ct: {4'd0, 4'd0, 4'd0}, cd: {32'h0, 32'h0, 32'h1234},
                  e_cnt: 2, e_rdy: 1, e_fv: 3'b001, e_fd0: 32'h1234, e_fp0: 6'd33};
        vt[3] = '{default: '0, e_cnt: 0, e_rdy: 1, e_rv: 2'b11, e_wr: 2'b11,
                  e_d0: 32'h1234, e_d1: 32'hBEEF, e_f0: 6'd3, e_f1: 6'd4};
        vt[4] = '{default: '0, av: 2'b01, st: 1, a: 5'd7, e_cnt: 1, e_rdy: 1};
        vt[5] = '{default: '0, cv: 3'b001, ct: {4'd0, 4'd0, 4'd2}, cd: {32'h0, 32'h0, 32'h55},
                  e_cnt: 1, e_rdy: 1, e_fv: 3'b001, e_fd0: 32'h55, e_fp0: 6'd37};
        vt[6] = '{default: '0, e_cnt: 0, e_rdy: 1, e_rv: 2'b01, e_st: 2'b01, e_d0: 32'h55};
        vt[7] = '{default: '0, av: 2'b01, a: 5'd9, e_cnt: 1, e_rdy: 1};
        vt[8] = '{default: '0, cv: 3'b111, ct: {4'd3, 4'd5, 4'd3}, cd: {32'h222, 32'h999, 32'h111},
                  e_cnt: 1, e_rdy: 1, e_fv: 3'b101, e_fd0: 32'h111, e_fp0: 6'd39};
        vt[9] = '{default: '0, e_cnt: 0, e_rdy: 1, e_rv: 2'b01, e_wr: 2'b01,
                  e_d0: 32'h222, e_f0: 6'd9};

        for (int i = 0; i < 10; i++) begin
            clear_in();
            set_alloc(vt[i].av, vt[i].a, vt[i].st);
            bus.cmp_valid_i = vt[i].cv;
            bus.cmp_tag_i   = vt[i].ct;
            bus.cmp_data_i  = vt[i].cd;
            step();
            chk($sformatf("v%0d_count", i), count, vt[i].e_cnt);
            chk($sformatf("v%0d_ready", i), bus.alloc_ready_o, vt[i].e_rdy);
            chk($sformatf("v%0d_rt_valid", i), bus.rt_valid_o, vt[i].e_rv);
            chk($sformatf("v%0d_rt_wr", i), bus.rt_wr_o, vt[i].e_wr);
            chk($sformatf("v%0d_rt_store", i), bus.rt_store_o, vt[i].e_st);
            chk($sformatf("v%0d_fwd_valid", i), bus.fwd_valid_o, vt[i].e_fv);
            if (vt[i].e_rv[0]) chk($sformatf("v%0d_rt_data0", i), bus.rt_data_o[0], vt[i].e_d0);
            if (vt[i].e_rv[1]) chk($sformatf("v%0d_rt_data1", i), bus.rt_data_o[1], vt[i].e_d1);
            if (vt[i].e_wr[0]) chk($sformatf("v%0d_free0", i), bus.rt_free_preg_o[0], vt[i].e_f0);
            if (vt[i].e_wr[1]) chk($sformatf("v%0d_free1", i), bus.rt_free_preg_o[1], vt[i].e_f1);
            if (vt[i].e_fv[0]) begin
                chk($sformatf("v%0d_fwd_data0", i), bus.fwd_data_o[0], vt[i].e_fd0);
                chk($sformatf("v%0d_fwd_preg0", i), bus.fwd_preg_o[0], vt[i].e_fp0);
            end
        end

        // 3: fill to full, stall, drain two, wrap tags
        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fill%0d_tag0", i), bus.alloc_tag_o[0], 32'(2 * i));
            chk($sformatf("fill%0d_tag1", i), bus.alloc_tag_o[1], 32'(2 * i + 1));
            set_alloc(2'b11, 5'd1, 1'b0);
            step();
        end
        chk("full_count", count, 16);
        chk("full_full", full, 1);
        chk("full_ready", bus.alloc_ready_o, 0);
        set_alloc(2'b11, 5'd1, 1'b0);
        step();
        chk("full_ignored_count", count, 16);
        clear_in();
        set_cmp(0, 4'd0, 32'hA0);
        set_cmp(1, 4'd1, 32'hA1);
        step();
        chk("full_cmp_fwd", bus.fwd_valid_o, 3'b011);
        clear_in();
        step();
        chk("drain_rt_valid", bus.rt_valid_o, 2'b11);
        chk("drain_count", count, 14);
        chk("drain_ready", bus.alloc_ready_o, 1);
        chk("wrap_tag0", bus.alloc_tag_o[0], 0);
        chk("wrap_tag1", bus.alloc_tag_o[1], 1);
        set_alloc(2'b11, 5'd1, 1'b0);
        step();
        chk("wrap_count", count, 16);

        // 5: flush with completed entries pending
        do_reset();
        set_alloc(2'b11, 5'd1, 1'b0); step();
        set_alloc(2'b11, 5'd1, 1'b0); step();
        set_alloc(2'b01, 5'd1, 1'b0); step();
        chk("pre_flush_count", count, 5);
        clear_in();
        set_cmp(0, 4'd0, 32'h10);
        set_cmp(1, 4'd1, 32'h11);
        step();
        clear_in();
        flush = 1'b1;
        step();
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_rt_valid", bus.rt_valid_o, 0);
        chk("flush_fwd_valid", bus.fwd_valid_o, 0);
        clear_in();
        set_cmp(0, 4'd0, 32'h77);
        step();
        chk("post_flush_cmp_fwd", bus.fwd_valid_o, 0);
        clear_in();
        step();
        chk("post_flush_rt_valid", bus.rt_valid_o, 0);
        chk("post_flush_tag0", bus.alloc_tag_o[0], 0);
        set_alloc(2'b01, 5'd1, 1'b0);
        step();
        chk("post_flush_count", count, 1);

        // 6: done after three retirements, sticky
        do_reset();
        tot = 32'd3;
        set_alloc(2'b11, 5'd1, 1'b0); step();
        set_alloc(2'b01, 5'd1, 1'b0); step();
        clear_in();
        set_cmp(0, 4'd0, 32'h1);
        set_cmp(1, 4'd1, 32'h2);
        set_cmp(2, 4'd2, 32'h3);
        step();
        chk("done_pre", done, 0);
        clear_in();
        step();
        chk("done_ret2_cnt", retired_cnt, 2);
        chk("done_ret2_done", done, 0);
        chk("done_ret2_rt", bus.rt_valid_o, 2'b11);
        step();
        chk("done_ret3_cnt", retired_cnt, 3);
        chk("done_ret3_done", done, 1);
        chk("done_ret3_rt", bus.rt_valid_o, 2'b01);
        set_alloc(2'b11, 5'd1, 1'b0); step();
        set_alloc(2'b11, 5'd1, 1'b0); step();
        chk("done_sticky", done, 1);
        clear_in();
        flush = 1'b1;
        step();
        clear_in();
        chk("flush_keeps_done", done, 1);
        chk("flush_keeps_cnt", retired_cnt, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
